cdb_arbiter: RTL

Shares the single result-broadcast bus (broadcast_flag/Map/val to issue queue, physical register file, LSQ and ROB) between the EXE ALU result path and the LSQ load-completion path. The ALU path cannot stall, so its results that lose arbitration are held in a small FIFO. The LSQ path uses a valid/ready handshake. The winner of each cycle is registered onto the bus.

---
 rtl/cdb_pkg.sv | 12 +
 rtl/cdb_fifo.sv | 39 +++
 rtl/cdb_arbiter.sv | 80 ++++++++
 3 files changed

// File: rtl/cdb_pkg.sv
// cdb_pkg: shared result-bus entry type and grant encodings for CDB producers/consumers
package cdb_pkg;
  localparam int TAG_W = 6;
  localparam int DATA_W = 32;
  localparam logic GRANT_ALU = 1'b0;
  localparam logic GRANT_LSQ = 1'b1;
  typedef struct packed {
    logic [TAG_W-1:0]  map;
    logic [DATA_W-1:0] val;
    logic [31:0]       instr_num;
  } cdb_entry_t;
endpackage

// File: rtl/cdb_fifo.sv
// cdb_fifo: DEPTH-entry circular buffer of cdb_entry_t holding ALU results that lost the bus
//   CLK/RESET  clock, async active-low reset (pointers and count only; storage is not cleared)
//   push_i     write din_i at the tail (caller guarantees not full unless popping)
//   pop_i      drop the head entry (caller guarantees count_o > 0)
//   head_o     oldest entry; count_o  occupancy 0..DEPTH
module cdb_fifo
  import cdb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        push_i,
  input  logic        pop_i,
  input  cdb_entry_t  din_i,
  output cdb_entry_t  head_o,
  output logic [PW:0] count_o
);
  cdb_entry_t mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [PW:0] cnt_q;
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
    end
  end
  always_ff @(posedge CLK) begin
    if (push_i) mem_q[wr_q] <= din_i;
  end
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the result-broadcast bus between the non-stallable ALU path and the LSQ
//   CLK/RESET                 clock, async active-low reset
//   alu_valid/map/val/instr   EXE result, buffered when it cannot be broadcast this cycle
//   lsq_valid/map/val/instr   completed load; lsq_ready (combinational) consumes it this edge
//   broadcast_*               registered bus; complete_flag_rob mirrors broadcast_flag
//   alu_almost_full           registered, FIFO occupancy >= DEPTH-1, throttles issue
//   overflow_err              sticky, an ALU result was dropped
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              alu_valid,
  input  logic [TAG_W-1:0]  alu_map,
  input  logic [DATA_W-1:0] alu_val,
  input  logic [31:0]       alu_instr_num,
  input  logic              lsq_valid,
  input  logic [TAG_W-1:0]  lsq_map,
  input  logic [DATA_W-1:0] lsq_val,
  input  logic [31:0]       lsq_instr_num,
  output logic              lsq_ready,
  output logic              broadcast_flag,
  output logic [TAG_W-1:0]  broadcast_Map,
  output logic [DATA_W-1:0] broadcast_val,
  output logic [31:0]       broadcast_instr_num,
  output logic              complete_flag_rob,
  output logic              alu_almost_full,
  output logic              overflow_err
);
  localparam int PW = $clog2(DEPTH);
  cdb_entry_t alu_in, lsq_in, head, alu_cand, win, bus_q;
  logic [PW:0] count, count_d;
  logic full, alu_cand_v, grant_alu, grant_lsq, push, pop, drop, push_ok;
  logic last_grant_q, flag_q, almost_full_q, overflow_q;
  assign alu_in     = '{map: alu_map, val: alu_val, instr_num: alu_instr_num};
  assign lsq_in     = '{map: lsq_map, val: lsq_val, instr_num: lsq_instr_num};
  assign full       = count == (PW+1)'(DEPTH);
  // A non-empty FIFO always presents its head so ALU results stay in order.
  assign alu_cand_v = alu_valid || count != '0;
  assign alu_cand   = count != '0 ? head : alu_in;
  // A full FIFO forces the ALU side so the next EXE result always has room.
  assign grant_alu  = alu_cand_v && (full || !lsq_valid || last_grant_q == GRANT_LSQ);
  assign grant_lsq  = lsq_valid && !grant_alu;
  assign lsq_ready  = grant_lsq;
  // The incoming result is buffered unless it was the one that went straight to the bus.
  assign push       = alu_valid && !(grant_alu && count == '0);
  assign pop        = grant_alu && count != '0;
  assign drop       = push && full && !pop;
  assign push_ok    = push && !drop;
  assign count_d    = count + (PW+1)'(push_ok) - (PW+1)'(pop);
  assign win        = grant_alu ? alu_cand : lsq_in;
  cdb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK(CLK), .RESET(RESET), .push_i(push_ok), .pop_i(pop),
    .din_i(alu_in), .head_o(head), .count_o(count)
  );
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      last_grant_q  <= GRANT_LSQ;
      flag_q        <= 1'b0;
      bus_q         <= '0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      if (alu_cand_v && lsq_valid) last_grant_q <= grant_alu ? GRANT_ALU : GRANT_LSQ;
      flag_q <= grant_alu || grant_lsq;
      if (grant_alu || grant_lsq) bus_q <= win;
      almost_full_q <= count_d >= (PW+1)'(DEPTH-1);
      if (drop) overflow_q <= 1'b1;
    end
  end
  assign broadcast_flag      = flag_q;
  assign complete_flag_rob   = flag_q;
  assign broadcast_Map       = bus_q.map;
  assign broadcast_val       = bus_q.val;
  assign broadcast_instr_num = bus_q.instr_num;
  assign alu_almost_full     = almost_full_q;
  assign overflow_err        = overflow_q;
endmodule
